// File: rtl/aes_enc_iter.sv
// rtl/aes_enc_iter.sv - iterative AES-128/256 encryptor, one round per clock, on-the-fly key schedule
// Optional AES_KEY_REUSE_EN adds key_reuse and a stored-key register.
module aes_enc_iter #(
    parameter int KEY_L  = 128,
    parameter int DATA_W = 128
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_in,
    output logic              ready_in,
    input  logic [KEY_L-1:0]  cipher_key,
    input  logic [DATA_W-1:0] plain_text,
`ifdef AES_KEY_REUSE_EN
    input  logic              key_reuse,
`endif
    output logic [DATA_W-1:0] cipher_text,
    output logic              valid_out,
    input  logic              ready_out,
    output logic              busy
);
    generate
        if ((KEY_L != 128 && KEY_L != 256) || DATA_W != 128) begin : g_bad_param
            $error("aes_enc_iter: KEY_L must be 128 or 256 and DATA_W must be 128");
        end
    endgenerate

    localparam logic [3:0] NR = (KEY_L == 256) ? 4'd14 : 4'd10;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state_q, state_d;

    logic [DATA_W-1:0] blk_q, round_out, rk;
    logic [KEY_L-1:0]  key_q, key_src, key_next;
    logic [7:0]        rcon_q;
    logic [3:0]        round_q;
    logic              accept, rcon_step, first_256;
    logic [31:0]       w0, w1, w2, w3, wl, sub_in, temp, n0, n1, n2, n3;
    logic [127:0]      new4;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Inverse as x^254 by an addition chain (0 maps to 0), then the affine transform.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] x2, x3, x12, x15, x240, inv;
        x2   = gf_mul(x, x);
        x3   = gf_mul(x2, x);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        inv  = gf_mul(gf_mul(x240, x12), x2);
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                   ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Byte i of the state sits at bits [127-8i -: 8]; row = i%4, column = i/4.
    function automatic logic [127:0] sub_shift(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

`ifdef AES_KEY_REUSE_EN
    logic [KEY_L-1:0] stored_key_q;
    assign key_src = key_reuse ? stored_key_q : cipher_key;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stored_key_q <= '0;
        end else if (accept && !key_reuse) begin
            stored_key_q <= cipher_key;
        end
    end
`else
    assign key_src = cipher_key;
`endif

    // Window always holds the eight (or four) newest key words; the oldest four seed the next four.
    assign w0        = key_q[KEY_L-1  -: 32];
    assign w1        = key_q[KEY_L-33 -: 32];
    assign w2        = key_q[KEY_L-65 -: 32];
    assign w3        = key_q[KEY_L-97 -: 32];
    assign wl        = key_q[31:0];
    assign rcon_step = (KEY_L == 128) || !round_q[0];
    assign first_256 = (KEY_L == 256) && (round_q == 4'd1);
    assign sub_in    = rcon_step ? {wl[23:0], wl[31:24]} : wl;
    assign temp      = sub_word(sub_in) ^ (rcon_step ? {rcon_q, 24'h000000} : 32'h0);
    assign n0        = w0 ^ temp;
    assign n1        = w1 ^ n0;
    assign n2        = w2 ^ n1;
    assign n3        = w3 ^ n2;
    assign new4      = {n0, n1, n2, n3};
    assign rk        = first_256 ? key_q[127:0] : new4;

    generate
        if (KEY_L == 256) begin : g_k256
            assign key_next = {key_q[127:0], new4};
        end else begin : g_k128
            assign key_next = new4;
        end
    endgenerate

    always_comb begin
        logic [127:0] sr;
        sr        = sub_shift(blk_q);
        round_out = ((round_q == NR) ? sr : mix_columns(sr)) ^ rk;
    end

    always_comb begin
        state_d   = state_q;
        ready_in  = 1'b0;
        busy      = 1'b0;
        valid_out = 1'b0;
        case (state_q)
            IDLE: begin
                ready_in = 1'b1;
                if (valid_in) state_d = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (round_q == NR) state_d = DONE;
            end
            DONE: begin
                valid_out = 1'b1;
                ready_in  = ready_out;
                if (ready_out) state_d = valid_in ? RUN : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign accept = valid_in && ready_in;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            blk_q       <= '0;
            key_q       <= '0;
            rcon_q      <= 8'h01;
            round_q     <= 4'd0;
            cipher_text <= '0;
        end else if (accept) begin
            key_q   <= key_src;
            blk_q   <= plain_text ^ key_src[KEY_L-1 -: 128];
            round_q <= 4'd1;
            rcon_q  <= 8'h01;
        end else if (state_q == RUN) begin
            blk_q   <= round_out;
            round_q <= round_q + 4'd1;
            if (!first_256) key_q <= key_next;
            if (!first_256 && rcon_step) rcon_q <= xtime(rcon_q);
            if (round_q == NR) cipher_text <= round_out;
        end
    end
endmodule

// File: tb/tb_aes_enc_iter.sv
// tb/tb_aes_enc_iter.sv - directed FIPS-197 vector bench for aes_enc_iter (128 and 256 instances)
module tb_aes_enc_iter;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic         valid_in, ready_in, valid_out, ready_out, busy;
    logic [127:0] cipher_key, plain_text, cipher_text;
    logic         valid_in_w, ready_in_w, valid_out_w, ready_out_w, busy_w;
    logic [255:0] cipher_key_w;
    logic [127:0] plain_text_w, cipher_text_w;
`ifdef AES_KEY_REUSE_EN
    logic         key_reuse, key_reuse_w;
`endif

    int checks   = 0;
    int failures = 0;

    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [255:0] KEY_W = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [127:0] CT_W  = 128'h8ea2b7ca516745bfeafc49904b496089;

    aes_enc_iter #(.KEY_L(128), .DATA_W(128)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_in(ready_in),
        .cipher_key(cipher_key), .plain_text(plain_text),
`ifdef AES_KEY_REUSE_EN
        .key_reuse(key_reuse),
`endif
        .cipher_text(cipher_text), .valid_out(valid_out), .ready_out(ready_out), .busy(busy)
    );

    aes_enc_iter #(.KEY_L(256), .DATA_W(128)) dut_w (
        .clk(clk), .reset(reset), .valid_in(valid_in_w), .ready_in(ready_in_w),
        .cipher_key(cipher_key_w), .plain_text(plain_text_w),
`ifdef AES_KEY_REUSE_EN
        .key_reuse(key_reuse_w),
`endif
        .cipher_text(cipher_text_w), .valid_out(valid_out_w), .ready_out(ready_out_w), .busy(busy_w)
    );

    // Counts edges after the accepting edge until valid_out rises; 40 means it never did.
    task automatic wait_valid(output int n);
        n = 0;
        while (n < 40 && valid_out !== 1'b1) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic accept_block(input logic [127:0] k, input logic [127:0] p);
        cipher_key = k;
        plain_text = p;
        valid_in   = 1'b1;
        @(posedge clk); #1;
        valid_in   = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        #2;
        checks++; if (ready_in !== 1'b1) begin failures++; $display("FAIL reset_ready_in: got %b want 1", ready_in); end
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid_out: got %b want 0", valid_out); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (cipher_text !== 128'h0) begin failures++; $display("FAIL reset_ct: got %h want 0", cipher_text); end
        checks++; if (ready_in_w !== 1'b1) begin failures++; $display("FAIL reset_ready_in_w: got %b want 1", ready_in_w); end
        checks++; if (cipher_text_w !== 128'h0) begin failures++; $display("FAIL reset_ct_w: got %h want 0", cipher_text_w); end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_fips128;
        int n;
        ready_out = 1'b1;
        accept_block(KEY_A, PT_A);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL f128_busy: got %b want 1", busy); end
        checks++; if (ready_in !== 1'b0) begin failures++; $display("FAIL f128_ready_in_run: got %b want 0", ready_in); end
        wait_valid(n);
        checks++; if (n != 10) begin failures++; $display("FAIL f128_latency: got %0d want 10", n); end
        checks++; if (cipher_text !== CT_A) begin failures++; $display("FAIL f128_ct: got %h want %h", cipher_text, CT_A); end
        checks++; if (ready_in !== 1'b1) begin failures++; $display("FAIL f128_ready_in_done: got %b want 1", ready_in); end
        @(posedge clk); #1;
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL f128_consumed: got %b want 0", valid_out); end
    endtask

    task automatic test_fips256;
        int n;
        ready_out_w  = 1'b1;
        cipher_key_w = KEY_W;
        plain_text_w = PT_A;
        valid_in_w   = 1'b1;
        @(posedge clk); #1;
        valid_in_w   = 1'b0;
        n = 0;
        while (n < 40 && valid_out_w !== 1'b1) begin
            @(posedge clk); #1;
            n++;
        end
        checks++; if (n != 14) begin failures++; $display("FAIL f256_latency: got %0d want 14", n); end
        checks++; if (cipher_text_w !== CT_W) begin failures++; $display("FAIL f256_ct: got %h want %h", cipher_text_w, CT_W); end
        @(posedge clk); #1;
        checks++; if (valid_out_w !== 1'b0) begin failures++; $display("FAIL f256_consumed: got %b want 0", valid_out_w); end
    endtask

    task automatic test_stall;
        int n;
        ready_out = 1'b0;
        accept_block(KEY_B, PT_B);
        cipher_key = 128'h0;
        plain_text = '1;
        wait_valid(n);
        checks++; if (n != 10) begin failures++; $display("FAIL stall_latency: got %0d want 10", n); end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++; if (valid_out !== 1'b1) begin failures++; $display("FAIL stall_valid_out: got %b want 1", valid_out); end
            checks++; if (cipher_text !== CT_B) begin failures++; $display("FAIL stall_ct: got %h want %h", cipher_text, CT_B); end
            checks++; if (ready_in !== 1'b0) begin failures++; $display("FAIL stall_ready_in: got %b want 0", ready_in); end
        end
        ready_out = 1'b1;
        #1;
        checks++; if (ready_in !== 1'b1) begin failures++; $display("FAIL stall_ready_in_release: got %b want 1", ready_in); end
        @(posedge clk); #1;
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL stall_consumed: got %b want 0", valid_out); end
    endtask

    task automatic test_back_to_back;
        int n;
        ready_out  = 1'b1;
        cipher_key = KEY_A;
        plain_text = PT_A;
        valid_in   = 1'b1;
        @(posedge clk); #1;
        cipher_key = KEY_B;
        plain_text = PT_B;
        wait_valid(n);
        checks++; if (n != 10) begin failures++; $display("FAIL b2b_latency_a: got %0d want 10", n); end
        checks++; if (cipher_text !== CT_A) begin failures++; $display("FAIL b2b_ct_a: got %h want %h", cipher_text, CT_A); end
        checks++; if (ready_in !== 1'b1) begin failures++; $display("FAIL b2b_ready_in: got %b want 1", ready_in); end
        @(posedge clk); #1;
        valid_in = 1'b0;
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL b2b_valid_drop: got %b want 0", valid_out); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_busy: got %b want 1", busy); end
        wait_valid(n);
        checks++; if (n + 1 != 11) begin failures++; $display("FAIL b2b_spacing: got %0d want 11", n + 1); end
        checks++; if (cipher_text !== CT_B) begin failures++; $display("FAIL b2b_ct_b: got %h want %h", cipher_text, CT_B); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid;
        int n;
        ready_out = 1'b1;
        accept_block(KEY_A, PT_A);
        repeat (4) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL rmid_busy: got %b want 1", busy); end
        reset = 1'b1;
        #1;
        checks++; if (valid_out !== 1'b0) begin failures++; $display("FAIL rmid_valid_out: got %b want 0", valid_out); end
        checks++; if (ready_in !== 1'b1) begin failures++; $display("FAIL rmid_ready_in: got %b want 1", ready_in); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rmid_busy_clr: got %b want 0", busy); end
        checks++; if (cipher_text !== 128'h0) begin failures++; $display("FAIL rmid_ct: got %h want 0", cipher_text); end
        @(posedge clk); #1;
        reset = 1'b0;
        accept_block(KEY_B, PT_B);
        wait_valid(n);
        checks++; if (n != 10) begin failures++; $display("FAIL rmid_latency: got %0d want 10", n); end
        checks++; if (cipher_text !== CT_B) begin failures++; $display("FAIL rmid_ct_after: got %h want %h", cipher_text, CT_B); end
        @(posedge clk); #1;
    endtask

`ifdef AES_KEY_REUSE_EN
    task automatic test_key_reuse;
        int n;
        ready_out = 1'b1;
        key_reuse = 1'b0;
        accept_block(KEY_A, PT_B);
        wait_valid(n);
        @(posedge clk); #1;
        key_reuse = 1'b1;
        accept_block(128'h0, PT_A);
        key_reuse = 1'b0;
        wait_valid(n);
        checks++; if (n != 10) begin failures++; $display("FAIL reuse_latency: got %0d want 10", n); end
        checks++; if (cipher_text !== CT_A) begin failures++; $display("FAIL reuse_ct: got %h want %h", cipher_text, CT_A); end
        @(posedge clk); #1;
    endtask
`endif

    initial begin
        reset        = 1'b1;
        valid_in     = 1'b0;
        ready_out    = 1'b0;
        cipher_key   = '0;
        plain_text   = '0;
        valid_in_w   = 1'b0;
        ready_out_w  = 1'b0;
        cipher_key_w = '0;
        plain_text_w = '0;
`ifdef AES_KEY_REUSE_EN
        key_reuse    = 1'b0;
        key_reuse_w  = 1'b0;
`endif
        test_reset();
        test_fips128();
        test_fips256();
        test_stall();
        test_back_to_back();
        test_reset_mid();
`ifdef AES_KEY_REUSE_EN
        test_key_reuse();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
